cmp_seq_ctrl: RTL
=================

Name: cmp_seq_ctrl

Overview:
Multi-cycle magnitude-comparator sequencer for the Mini ALU. It latches two WIDTH-bit operands on a start request and walks them MSB-first, one 2-bit slice per cycle, using a 2-bit greater-than/less-than slice evaluation. It reports registered gt/eq/lt flags with a one-cycle done pulse. It sits between the ALU op decoder and the result mux, so wide compares run on a single 2-bit comparator slice instead of a flat WIDTH-bit comparator.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (N = WIDTH/2 slices).

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; accepted only when busy = 0
a  input  WIDTH  operand A, sampled on the accepting edge only
b  input  WIDTH  operand B, sampled on the accepting edge only
busy  output  1  high while in COMPARE
done  output  1  single-cycle pulse when the result flags become valid
a_gt_b  output  1  registered result, A > B (unsigned)
a_eq_b  output  1  registered result, A == B
a_lt_b  output  1  registered result, A < B (unsigned)

Behaviour:
- Reset (reset_n = 0 at an edge): state = IDLE; busy, done, a_gt_b, a_eq_b, a_lt_b = 0. The operand registers and slice index are don't-care.
- Reset mid-COMPARE aborts the operation. No done pulse is produced and the flags read 0.
- States and transitions:
  - IDLE: start = 1 latches a and b, sets index = N-1, clears the three flags and the internal decided bit, and moves to COMPARE.
  - COMPARE: busy = 1. Each cycle evaluates slice a_r[2i+1:2i] against b_r[2i+1:2i], unsigned.
    - gt2 = (a1 & ~b1) | (a0 & ~b1 & ~b0) | (a1 & a0 & ~b0); lt2 is the same function with operands swapped.
    - If not yet decided and gt2 or lt2 is set: record the direction and set decided. The first deciding slice wins, and later slices never override it.
    - index decrements each cycle. On index = 0, or on the early-exit condition (see Optional Feature), go to DONE.
  - DONE: exactly one cycle. done = 1, busy = 0.
    - Flags are written this cycle: gt or lt from the decided direction; eq = 1 if never decided.
    - Exactly one flag is high. Flags hold until the next accepted start.
    - start = 1 in DONE is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- start while busy = 1 is ignored, and operand inputs are not re-sampled.
- Latency: start sampled at edge E0. In full-scan mode, done is high during the cycle after edge E0+N+1, so done rises N+1 edges after the start edge. Throughput is one compare per N+1 cycles with back-to-back starts.
- Flags are all 0 from an accepted start until its done, so a result is never stale-but-valid.
- All outputs are driven directly from registers, with no combinational path from inputs.

Optional Feature:
Macro CMP_EARLY_EXIT_EN.
- Defined: COMPARE moves to DONE on the same edge a slice first decides. Latency is k+1 edges for a decision at slice k (k = 1 is the MSB slice). Equal operands still take N+1.
- Undefined: every compare takes exactly N+1 edges regardless of data (constant-time).
- Flag values are identical in both builds.

Test Plan:
- WIDTH=8, a=0xC5, b=0x3A, start pulse -> a_gt_b=1, eq=lt=0; done 2 edges after start with CMP_EARLY_EXIT_EN, 5 edges without; busy high for 1 vs 4 cycles.
- a=0x5A, b=0x5A -> a_eq_b=1 only; done 5 edges after start in both builds.
- a=0x12, b=0x13 (decided at the LSB slice) -> a_lt_b=1 only; done 5 edges after start in both builds.
- a=0x80, b=0x7F, then start with a=0x00, b=0xFF held for 2 cycles while busy -> the second request is ignored; result is a_gt_b=1 and busy drops once.
- Back-to-back: start held high continuously with alternating operands (0x40/0x30, 0x30/0x40) -> done every N+1 (or early-exit) cycles; flags alternate gt then lt and read 0 between each accepted start and its done.
- reset_n pulled low for 1 cycle in the 2nd COMPARE cycle -> the next edge gives state IDLE with all outputs 0 and no done pulse; a following start of 0x01 vs 0x00 completes normally with a_gt_b=1.

Source files
------------

// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle magnitude comparator: walks two latched operands MSB-first, one 2-bit slice per cycle.
// Optional macro CMP_EARLY_EXIT_EN: finish on the first deciding slice instead of scanning all slices.
module cmp_seq_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b
);

   localparam int unsigned N  = WIDTH / 2;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [IW-1:0]    idx;
   logic             decided;
   logic             dir_gt;

   logic [1:0]       sa;
   logic [1:0]       sb;
   logic             gt2;
   logic             lt2;
   logic             hit;
   logic             accept;
   logic             exit_c;

   logic             busy_d;
   logic             done_d;
   logic             gt_d;
   logic             eq_d;
   logic             lt_d;

   // Single 2-bit slice comparator, steered by the slice index
   assign sa  = 2'(a_r >> {idx, 1'b0});
   assign sb  = 2'(b_r >> {idx, 1'b0});
   assign gt2 = (sa[1] & ~sb[1]) | (sa[0] & ~sb[1] & ~sb[0]) | (sa[1] & sa[0] & ~sb[0]);
   assign lt2 = (sb[1] & ~sa[1]) | (sb[0] & ~sa[1] & ~sa[0]) | (sb[1] & sb[0] & ~sa[0]);
   assign hit = ~decided & (gt2 | lt2);

   assign accept = start && (state != COMPARE);

`ifdef CMP_EARLY_EXIT_EN
   assign exit_c = (idx == '0) || hit;
`else
   assign exit_c = (idx == '0);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = COMPARE;
         COMPARE: if (exit_c) state_nx = DONE;
         DONE:    state_nx = start ? COMPARE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered outputs; a DONE-cycle restart still publishes the old result first
   always_comb begin
      busy_d = (state_nx == COMPARE);
      done_d = (state == DONE);
      gt_d   = a_gt_b;
      eq_d   = a_eq_b;
      lt_d   = a_lt_b;
      if (state == DONE) begin
         gt_d = decided & dir_gt;
         lt_d = decided & ~dir_gt;
         eq_d = ~decided;
      end else if (accept || (state == COMPARE)) begin
         gt_d = 1'b0;
         eq_d = 1'b0;
         lt_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         a_gt_b <= 1'b0;
         a_eq_b <= 1'b0;
         a_lt_b <= 1'b0;
      end else begin
         busy   <= busy_d;
         done   <= done_d;
         a_gt_b <= gt_d;
         a_eq_b <= eq_d;
         a_lt_b <= lt_d;
      end
   end

   // Operand capture and slice walk; the first deciding slice is sticky
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         decided <= 1'b0;
         dir_gt  <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= b;
         idx     <= IW'(N - 1);
         decided <= 1'b0;
         dir_gt  <= 1'b0;
      end else if (state == COMPARE) begin
         idx <= idx - IW'(1);
         if (hit) begin
            decided <= 1'b1;
            dir_gt  <= gt2;
         end
      end
   end

endmodule
